// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back request bus between execute units and the arbiter
// req_valid/req_addr/req_data: per-requester request, driven by master
// req_ready: one-hot-or-zero grant, driven by slave
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter and busy scoreboard for the register file
// clk/reset: clock, synchronous active-high reset
// wb: write-back request bus (slave side)
// issue_valid/issue_addr: marks a destination register pending
// chk_addrA/chk_addrB/stall: hazard check of decode source registers
// busy: scoreboard; rf_writeAddress/rf_writeData: staged register file write (address 0 = none)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [ADDR_WIDTH-1:0] chk_addrA,
  input  logic [ADDR_WIDTH-1:0] chk_addrB,
  output logic stall,
  output logic [(1<<ADDR_WIDTH)-1:0] busy,
  output logic [ADDR_WIDTH-1:0] rf_writeAddress,
  output logic [DATA_WIDTH-1:0] rf_writeData
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr, nxt_ptr;
  logic [NUM_REQ-1:0] ready;
  logic found;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [(1<<ADDR_WIDTH)-1:0] busy_nxt;
  always_comb begin
    ready = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!reset && !found && wb.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        ready[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    sel_addr = '0;
    sel_data = '0;
    nxt_ptr = ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (ready[i]) begin
        sel_addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        nxt_ptr = PW'((i + 1) % NUM_REQ);
      end
  end
  // clear on the commit edge, then set so a new pending writer wins
  always_comb begin
    busy_nxt = busy;
    if (rf_writeAddress != '0) busy_nxt[rf_writeAddress] = 1'b0;
    if (issue_valid && issue_addr != '0) busy_nxt[issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      busy <= '0;
      rf_writeAddress <= '0;
      rf_writeData <= '0;
    end else begin
      ptr <= nxt_ptr;
      busy <= busy_nxt;
      rf_writeAddress <= found ? sel_addr : '0;
      if (found) rf_writeData <= sel_data;
    end
  assign wb.req_ready = ready;
  assign stall = busy[chk_addrA] | busy[chk_addrB];
endmodule
